// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, ExcCode values, SR/Cause bit positions.
// Latency: n/a (constants and one constant helper function only).
// Backpressure: n/a.
package cp0_pkg;

  // CP0 register numbers as seen by mtc0/mfc0
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  // ExcCode values produced by the decoder/pipeline; 0 doubles as "no exception"
  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  // SR bit positions
  localparam int SR_IE_BIT  = 0;
  localparam int SR_EXL_BIT = 1;
  localparam int SR_IM_LSB  = 10;
  localparam int SR_IP7_BIT = 15;

  // Cause bit positions
  localparam int CAUSE_BD_BIT  = 31;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_IP7_BIT = 15;

  // Writable SR bits: IE, EXL and one IM bit per external interrupt line
  function automatic logic [31:0] sr_impl_mask(input int hw);
    logic [31:0] m;
    m = '0;
    m[SR_IE_BIT]  = 1'b1;
    m[SR_EXL_BIT] = 1'b1;
    for (int i = 0; i < hw; i++) begin
      m[SR_IM_LSB+i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/cp0_exc_unit_if.sv
// M-stage <-> CP0 signal bundle: exception/interrupt inputs, mtc0/mfc0 port, flush request.
// Latency: n/a (wires only).
// Backpressure: none; req is a one-cycle flush request the pipeline must honour.
interface cp0_exc_unit_if #(
  parameter int HW_INT_NUM = 6
);
  logic [31:0]           pc_in;
  logic                  bd_in;
  logic [4:0]            exc_code_in;
  logic [HW_INT_NUM-1:0] hw_int;
  logic                  we;
  logic [4:0]            addr;
  logic [31:0]           wdata;
  logic                  exl_clr;
  logic [31:0]           rdata;
  logic                  req;
  logic [31:0]           handler_pc;
  logic [31:0]           epc_out;

  // Pipeline side
  modport master (
    output pc_in, bd_in, exc_code_in, hw_int, we, addr, wdata, exl_clr,
    input  rdata, req, handler_pc, epc_out
  );

  // CP0 side
  modport slave (
    input  pc_in, bd_in, exc_code_in, hw_int, we, addr, wdata, exl_clr,
    output rdata, req, handler_pc, epc_out
  );
endinterface

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with sticky pending flag (built only with CP0_TIMER_EN).
// Latency: pending visible the cycle after Count==Compare.
// Backpressure: none; Compare write clears pending and wins over a same-cycle match.
module cp0_timer (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cmp_we_i,
  input  logic [31:0] cmp_wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        pend_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        pend_q, pend_d;

  // Free-running count, Compare load, sticky match flag
  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    pend_d    = pend_q;
    if (cmp_we_i) begin
      compare_d = cmp_wdata_i;
      pend_d    = 1'b0;
    end else if (count_q == compare_q) begin
      pend_d    = 1'b1;
    end
  end

  // Timer state registers
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      count_q   <= '0;
      compare_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign pend_o    = pend_q;

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt unit: SR/Cause/EPC/PRId, flush request, ERET return address.
// Latency: req is combinational (0 cycles); register updates land at the next edge.
// Backpressure: none; while SR.EXL=1 no further requests are raised. Timer option: CP0_TIMER_EN.
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter int          HW_INT_NUM = 6,
  parameter logic [31:0] EXC_ENTRY  = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL   = 32'h4255_4141
) (
  input logic           clk,
  input logic           reset,
  cp0_exc_unit_if.slave bus
);

`ifdef CP0_TIMER_EN
  localparam logic [31:0] SR_WMASK = sr_impl_mask(HW_INT_NUM) | (32'd1 << SR_IP7_BIT);
`else
  localparam logic [31:0] SR_WMASK = sr_impl_mask(HW_INT_NUM);
`endif

  logic [31:0]           sr_q, sr_d;
  logic [31:0]           epc_q, epc_d;
  logic                  bd_q, bd_d;
  logic [4:0]            exc_q, exc_d;
  logic [HW_INT_NUM-1:0] ip_q;

  logic        int_req, exc_req, req, wr_ok, tmr_int;
  logic [31:0] cause_rd, rdata_c;

`ifdef CP0_TIMER_EN
  logic [31:0] count, compare;
  logic        tmr_pend;

  cp0_timer u_timer (
    .clk_i       (clk),
    .reset_i     (reset),
    .cmp_we_i    (wr_ok && (bus.addr == REG_COMPARE)),
    .cmp_wdata_i (bus.wdata),
    .count_o     (count),
    .compare_o   (compare),
    .pend_o      (tmr_pend)
  );

  assign tmr_int = tmr_pend & sr_q[SR_IP7_BIT];
`else
  assign tmr_int = 1'b0;
`endif

  // Live hw_int (not the sampled IP) drives interrupts so they are taken without a cycle of lag
  assign int_req = ((|(bus.hw_int & sr_q[SR_IM_LSB +: HW_INT_NUM])) | tmr_int)
                   & sr_q[SR_IE_BIT] & ~sr_q[SR_EXL_BIT];
  assign exc_req = (|bus.exc_code_in) & ~sr_q[SR_EXL_BIT];
  assign req     = int_req | exc_req;
  // An instruction being flushed must not commit its mtc0
  assign wr_ok   = bus.we & ~req;

  // Next state: mtc0 first, then ERET clear, then exception entry overrides
  always_comb begin
    sr_d  = sr_q;
    epc_d = epc_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    if (wr_ok && (bus.addr == REG_SR)) begin
      sr_d = bus.wdata & SR_WMASK;
    end
    if (wr_ok && (bus.addr == REG_EPC)) begin
      epc_d = bus.wdata;
    end
    if (bus.exl_clr) begin
      sr_d[SR_EXL_BIT] = 1'b0;
    end
    if (req) begin
      sr_d[SR_EXL_BIT] = 1'b1;
      bd_d             = bus.bd_in;
      exc_d            = int_req ? 5'(EXC_INT) : bus.exc_code_in;
      // Delay-slot faults restart at the branch; PC stored unmasked so AdEL keeps the bad address
      epc_d            = bus.bd_in ? (bus.pc_in - 32'd4) : bus.pc_in;
    end
  end

  // CP0 state registers; IP tracks the interrupt lines every cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_q  <= '0;
      epc_q <= '0;
      bd_q  <= 1'b0;
      exc_q <= '0;
      ip_q  <= '0;
    end else begin
      sr_q  <= sr_d;
      epc_q <= epc_d;
      bd_q  <= bd_d;
      exc_q <= exc_d;
      ip_q  <= bus.hw_int;
    end
  end

  // Assemble the Cause view from its fields
  always_comb begin
    cause_rd                                    = '0;
    cause_rd[CAUSE_BD_BIT]                      = bd_q;
    cause_rd[CAUSE_IP_LSB +: HW_INT_NUM]        = ip_q;
    cause_rd[CAUSE_EXC_LSB +: 5]                = exc_q;
`ifdef CP0_TIMER_EN
    cause_rd[CAUSE_IP7_BIT]                     = cause_rd[CAUSE_IP7_BIT] | tmr_pend;
`endif
  end

  // mfc0 read mux on pre-edge state
  always_comb begin
    rdata_c = '0;
    case (bus.addr)
      REG_SR:      rdata_c = sr_q;
      REG_CAUSE:   rdata_c = cause_rd;
      REG_EPC:     rdata_c = epc_q;
      REG_PRID:    rdata_c = PRID_VAL;
`ifdef CP0_TIMER_EN
      REG_COUNT:   rdata_c = count;
      REG_COMPARE: rdata_c = compare;
`endif
      default:     rdata_c = '0;
    endcase
  end

  assign bus.rdata      = rdata_c;
  assign bus.req        = req;
  assign bus.handler_pc = EXC_ENTRY;
  // Bypass lets an mtc0 EPC directly ahead of ERET take effect without a stall
  assign bus.epc_out    = (wr_ok && (bus.addr == REG_EPC)) ? bus.wdata : epc_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed self-checking bench for cp0_exc_unit.
// Latency: checks combinational outputs in-cycle and registers the cycle after.
// Backpressure: n/a.
module tb_cp0_exc_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

`ifdef CP0_TIMER_EN
  localparam logic [31:0] TPEND = 32'h0000_8000;
`else
  localparam logic [31:0] TPEND = 32'h0000_0000;
`endif

  cp0_exc_unit_if #(.HW_INT_NUM(6)) bus ();

  cp0_exc_unit #(
    .HW_INT_NUM (6),
    .EXC_ENTRY  (32'h0000_4180),
    .PRID_VAL   (32'h4255_4141)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we          = 1'b0;
    bus.exl_clr     = 1'b0;
    bus.exc_code_in = 5'd0;
    bus.bd_in       = 1'b0;
    bus.pc_in       = 32'd0;
    bus.addr        = 5'd0;
    bus.wdata       = 32'd0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    tick();
    bus.we    = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0;
    idle();
    bus.hw_int = '0;
    tick();
    tick();
    reset = 1'b1;
    rd(5'd12, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_sr: got %h expected %h", d, 32'h0); end
    rd(5'd13, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_cause: got %h expected %h", d, 32'h0); end
    rd(5'd14, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_epc: got %h expected %h", d, 32'h0); end
    rd(5'd15, d);
    n_checks++; if (d !== 32'h4255_4141) begin n_fail++; $display("FAIL reset_prid: got %h expected %h", d, 32'h4255_4141); end
    n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus.req); end
    n_checks++; if (bus.epc_out !== 32'h0) begin n_fail++; $display("FAIL reset_epc_out: got %h expected 0", bus.epc_out); end
    n_checks++; if (bus.handler_pc !== 32'h0000_4180) begin n_fail++; $display("FAIL handler_pc: got %h expected %h", bus.handler_pc, 32'h0000_4180); end
  endtask

  task automatic test_sync_exc();
    logic [31:0] d;
    bus.exc_code_in = 5'd12;
    bus.pc_in       = 32'h3010;
    bus.bd_in       = 1'b0;
    #1;
    n_checks++; if (bus.req !== 1'b1) begin n_fail++; $display("FAIL sync_req: got %b expected 1", bus.req); end
    tick();
    idle();
    rd(5'd14, d);
    n_checks++; if (d !== 32'h3010) begin n_fail++; $display("FAIL sync_epc: got %h expected %h", d, 32'h3010); end
    rd(5'd13, d);
    n_checks++; if (d !== (32'h30 | TPEND)) begin n_fail++; $display("FAIL sync_cause: got %h expected %h", d, 32'h30 | TPEND); end
    rd(5'd12, d);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL sync_sr_exl: got %h expected %h", d, 32'h2); end
    bus.exc_code_in = 5'd12;
    bus.pc_in       = 32'h3020;
    #1;
    n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL sync_nested_req: got %b expected 0", bus.req); end
    tick();
    idle();
    rd(5'd14, d);
    n_checks++; if (d !== 32'h3010) begin n_fail++; $display("FAIL sync_epc_held: got %h expected %h", d, 32'h3010); end
    bus.exl_clr = 1'b1;
    tick();
    idle();
    rd(5'd12, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL sync_exl_clr: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_delay_slot();
    logic [31:0] d;
    bus.bd_in       = 1'b1;
    bus.pc_in       = 32'h3008;
    bus.exc_code_in = 5'd10;
    #1;
    n_checks++; if (bus.req !== 1'b1) begin n_fail++; $display("FAIL bd_req: got %b expected 1", bus.req); end
    tick();
    idle();
    rd(5'd14, d);
    n_checks++; if (d !== 32'h3004) begin n_fail++; $display("FAIL bd_epc: got %h expected %h", d, 32'h3004); end
    rd(5'd13, d);
    n_checks++; if (d !== (32'h8000_0028 | TPEND)) begin n_fail++; $display("FAIL bd_cause: got %h expected %h", d, 32'h8000_0028 | TPEND); end
    bus.exl_clr = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_int_vs_exc();
    logic [31:0] d;
    wr(5'd12, 32'h0000_0401);
    rd(5'd12, d);
    n_checks++; if (d !== 32'h401) begin n_fail++; $display("FAIL ie_sr_write: got %h expected %h", d, 32'h401); end
    bus.hw_int      = 6'b000001;
    bus.exc_code_in = 5'd8;
    bus.pc_in       = 32'h3020;
    bus.we          = 1'b1;
    bus.addr        = 5'd14;
    bus.wdata       = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (bus.req !== 1'b1) begin n_fail++; $display("FAIL ie_req: got %b expected 1", bus.req); end
    n_checks++; if (bus.epc_out !== 32'h3004) begin n_fail++; $display("FAIL ie_epc_out_no_bypass: got %h expected %h", bus.epc_out, 32'h3004); end
    tick();
    idle();
    rd(5'd13, d);
    n_checks++; if (d !== (32'h400 | TPEND)) begin n_fail++; $display("FAIL ie_cause: got %h expected %h", d, 32'h400 | TPEND); end
    rd(5'd14, d);
    n_checks++; if (d !== 32'h3020) begin n_fail++; $display("FAIL ie_epc_write_dropped: got %h expected %h", d, 32'h3020); end
    rd(5'd12, d);
    n_checks++; if (d !== 32'h403) begin n_fail++; $display("FAIL ie_sr_exl: got %h expected %h", d, 32'h403); end
    n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL ie_no_nested_int: got %b expected 0", bus.req); end
    bus.hw_int = 6'b000000;
  endtask

  task automatic test_eret();
    logic [31:0] d;
    bus.we      = 1'b1;
    bus.addr    = 5'd14;
    bus.wdata   = 32'h3100;
    bus.exl_clr = 1'b1;
    #1;
    n_checks++; if (bus.epc_out !== 32'h3100) begin n_fail++; $display("FAIL eret_epc_bypass: got %h expected %h", bus.epc_out, 32'h3100); end
    n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL eret_req: got %b expected 0", bus.req); end
    tick();
    idle();
    rd(5'd12, d);
    n_checks++; if (d !== 32'h401) begin n_fail++; $display("FAIL eret_sr: got %h expected %h", d, 32'h401); end
    rd(5'd14, d);
    n_checks++; if (d !== 32'h3100) begin n_fail++; $display("FAIL eret_epc: got %h expected %h", d, 32'h3100); end
    bus.hw_int = 6'b000001;
    #1;
    n_checks++; if (bus.req !== 1'b1) begin n_fail++; $display("FAIL eret_int_reenabled: got %b expected 1", bus.req); end
    bus.hw_int = 6'b000000;
    #1;
  endtask

  task automatic test_masked_int();
    logic [31:0] d;
    wr(5'd12, 32'h0000_0001);
    bus.hw_int = 6'b111111;
    #1;
    n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL masked_req: got %b expected 0", bus.req); end
    bus.hw_int = 6'b101010;
    tick();
    bus.hw_int = 6'b000000;
    rd(5'd13, d);
    n_checks++; if (d !== (32'h0000_A800 | TPEND)) begin n_fail++; $display("FAIL masked_ip_sample: got %h expected %h", d, 32'h0000_A800 | TPEND); end
  endtask

  task automatic test_reg_access();
    logic [31:0] d;
    wr(5'd12, 32'hFFFF_FFFF);
    rd(5'd12, d);
    n_checks++; if (d !== 32'h0000_FC03) begin n_fail++; $display("FAIL sr_write_mask: got %h expected %h", d, 32'h0000_FC03); end
    wr(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, d);
    n_checks++; if (d !== TPEND) begin n_fail++; $display("FAIL cause_readonly: got %h expected %h", d, TPEND); end
    rd(5'd0, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h expected 0", d); end
`ifndef CP0_TIMER_EN
    wr(5'd11, 32'd5);
    rd(5'd11, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL compare_absent: got %h expected 0", d); end
    rd(5'd9, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL count_absent: got %h expected 0", d); end
`endif
    bus.we      = 1'b1;
    bus.addr    = 5'd12;
    bus.wdata   = 32'h0000_0403;
    bus.exl_clr = 1'b1;
    tick();
    idle();
    rd(5'd12, d);
    n_checks++; if (d !== 32'h401) begin n_fail++; $display("FAIL exl_clr_with_sr_write: got %h expected %h", d, 32'h401); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    bus.exc_code_in = 5'd4;
    bus.pc_in       = 32'h3013;
    bus.exl_clr     = 1'b1;
    #1;
    n_checks++; if (bus.req !== 1'b1) begin n_fail++; $display("FAIL b2b_first_req: got %b expected 1", bus.req); end
    tick();
    bus.exl_clr     = 1'b0;
    bus.exc_code_in = 5'd5;
    bus.pc_in       = 32'h4000;
    #1;
    n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL b2b_second_req: got %b expected 0", bus.req); end
    tick();
    idle();
    rd(5'd14, d);
    n_checks++; if (d !== 32'h3013) begin n_fail++; $display("FAIL b2b_epc_unaligned: got %h expected %h", d, 32'h3013); end
    rd(5'd13, d);
    n_checks++; if (d !== (32'h10 | TPEND)) begin n_fail++; $display("FAIL b2b_cause: got %h expected %h", d, 32'h10 | TPEND); end
    rd(5'd12, d);
    n_checks++; if (d !== 32'h403) begin n_fail++; $display("FAIL b2b_sr_req_beats_clr: got %h expected %h", d, 32'h403); end
    bus.exl_clr = 1'b1;
    tick();
    idle();
    bus.bd_in       = 1'b1;
    bus.pc_in       = 32'h0;
    bus.exc_code_in = 5'd8;
    tick();
    idle();
    rd(5'd14, d);
    n_checks++; if (d !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL epc_wrap: got %h expected %h", d, 32'hFFFF_FFFC); end
    rd(5'd13, d);
    n_checks++; if (d !== (32'h8000_0020 | TPEND)) begin n_fail++; $display("FAIL wrap_cause: got %h expected %h", d, 32'h8000_0020 | TPEND); end
    bus.exl_clr = 1'b1;
    tick();
    idle();
  endtask

`ifdef CP0_TIMER_EN
  task automatic test_timer();
    logic [31:0] d;
    logic [31:0] cnt;
    bit          seen;
    test_reset();
    wr(5'd11, 32'd5);
    wr(5'd12, 32'h0000_8001);
    seen = 1'b0;
    cnt  = '0;
    for (int i = 0; i < 20; i++) begin
      rd(5'd9, cnt);
      if (bus.req === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL timer_req_timeout: got %b expected 1", seen); end
    n_checks++; if (cnt !== 32'd6) begin n_fail++; $display("FAIL timer_count_at_req: got %0d expected 6", cnt); end
    rd(5'd13, d);
    n_checks++; if (d !== 32'h0000_8000) begin n_fail++; $display("FAIL timer_cause_ip7: got %h expected %h", d, 32'h0000_8000); end
    tick();
    wr(5'd11, 32'd100);
    rd(5'd13, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL timer_pend_clear: got %h expected 0", d); end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    idle();
    bus.hw_int = '0;
    test_reset();
    test_sync_exc();
    test_delay_slot();
    test_int_vs_exc();
    test_eret();
    test_masked_int();
    test_reg_access();
    test_back_to_back();
`ifdef CP0_TIMER_EN
    test_timer();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
Parametrised coprocessor-0 exception/interrupt unit. It is the stateful successor to the main decoder's exception-code priority logic. It sits beside the M stage, accepts the prioritised exception code of the instruction in M plus N external interrupt lines, and holds the SR/Cause/EPC/PRId registers. It raises a one-cycle pipeline flush request and supplies EPC for ERET.

Parameters:
HW_INT_NUM, 6, number of external interrupt lines (1..6); mapped to Cause.IP/SR.IM bits 10 upward.
EXC_ENTRY, 32'h0000_4180, handler PC driven on handler_pc.
PRID_VAL, 32'h4255_4141, constant returned on reads of register 15.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low reset
pc_in  in  32  PC of the instruction currently in M
bd_in  in  1  instruction in M is in a branch delay slot
exc_code_in  in  5  prioritised ExcCode from the decoder/pipeline; 0 = no exception
hw_int  in  HW_INT_NUM  external interrupt lines, level sensitive
we  in  1  mtc0 write enable (M stage)
addr  in  5  CP0 register number for mtc0/mfc0
wdata  in  32  mtc0 data
exl_clr  in  1  ERET in M: clear SR.EXL
rdata  out  32  mfc0 read data (combinational)
req  out  1  take exception/interrupt this cycle (combinational)
handler_pc  out  32  constant EXC_ENTRY
epc_out  out  32  return address for ERET

Behaviour:
- Reset (reset==0 at a clk edge): SR, Cause, EPC and the IP sample register all clear to 0. All outputs then follow from zeroed state: req=0, epc_out=0.
- SR (reg 12): IM[10+:HW_INT_NUM], EXL bit 1, IE bit 0. All other bits read 0 and are not writable.
- Cause (reg 13): BD bit 31, IP[10+:HW_INT_NUM], ExcCode[6:2]. Read-only to mtc0; writes are ignored.
- IP sampling: Cause.IP <= hw_int every cycle, including cycles where req=1.
- Request logic:
  - int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL. This uses live hw_int, not the sampled IP.
  - exc_req = (exc_code_in != 0) & ~SR.EXL.
  - req = int_req | exc_req.
- Priority: an interrupt beats a synchronous exception. On int_req, ExcCode <= 0; otherwise ExcCode <= exc_code_in.
- On req, at the next edge:
  - EXL <= 1.
  - BD <= bd_in.
  - EPC <= bd_in ? pc_in-4 : pc_in (32-bit wrap; no alignment masking, so an AdEL PC is stored as-is).
- mtc0: register write occurs at the edge when we=1 and req=0.
  - Writable targets: addr 12 (masked to the implemented SR bits) and addr 14.
  - If req=1, the write is dropped.
- exl_clr: SR.EXL <= 0 at the next edge.
  - If req=1 in the same cycle, req wins and EXL <= 1.
  - If exl_clr and an mtc0 to SR coincide, EXL is cleared and the other SR bits take wdata.
- epc_out: equals wdata when we & addr==14 & ~req (bypass for mtc0 immediately before ERET); otherwise equals the EPC register.
- rdata: 12→SR, 13→Cause, 14→EPC, 15→PRID_VAL; any other address → 0. Reads show pre-edge state, with no write bypass.
- No multi-cycle states. Exception latency is 0 cycles to req and 1 cycle to register update. While EXL=1, no nested requests are taken.

Optional Feature:
CP0_TIMER_EN. When defined:
- Reg 9 Count increments by 1 every cycle, wrapping at 2^32.
- Reg 11 Compare is writable.
- When Count==Compare, a sticky timer-pending bit sets; it appears as Cause bit 15 (IP7) and is maskable by SR bit 15.
- Writing Compare clears the pending bit.
- Timer pending ORs into int_req and, for ExcCode, has the same priority as hw_int.
- Count and Compare reset to 0; the pending bit resets to 0.

When not defined: regs 9/11 read 0, writes to them are ignored, and bit 15 reads 0.

Decomposition:
cp0_pkg holds:
- register numbers (SR=12, CAUSE=13, EPC=14, PRID=15, COUNT=9, COMPARE=11);
- ExcCode constants (INT=0, ADEL=4, ADES=5, SYSCALL=8, RI=10, OV=12);
- SR/Cause bit positions.

One sub-module, cp0_timer (Count/Compare/pending), is instantiated only under CP0_TIMER_EN.

Test Plan:
- Reset then read: hold reset=0 two cycles, then read addr 12/13/14/15 → 0, 0, 0, 32'h4255_4141; req=0.
- Synchronous exception: exc_code_in=12, pc_in=32'h3010, bd_in=0 → req=1 same cycle. Next cycle: EPC=32'h3010, ExcCode=12, EXL=1. Repeat exc_code_in=12 → req=0.
- Delay-slot exception: bd_in=1, pc_in=32'h3008, exc_code_in=10 → EPC=32'h3004, Cause bit31=1, ExcCode=10.
- Interrupt vs exception: SR=32'h0000_0401, hw_int=6'b000001, exc_code_in=8 in the same cycle → req=1, ExcCode=0; a simultaneous mtc0 to EPC is dropped.
- ERET path: mtc0 addr14 wdata=32'h3100 with exl_clr=1 → epc_out=32'h3100 that cycle; next cycle EXL=0 and EPC=32'h3100. Masked interrupt with IM=0 → req stays 0.
- Timer (CP0_TIMER_EN): write Compare=5 after reset; with SR=32'h0000_8001, req asserts once Count reaches 5. Write Compare again → pending bit clears.
